hyperbus_ctrl: RTL and testbench

//  Responder end of the hbus request interface used by the Wishbone bridge. Takes one 16-bit

---
 rtl/hyperbus_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_hyperbus_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_ctrl.sv
// hyperbus_ctrl: single-transaction HyperBus responder for the hbus request interface.
// Each accepted request runs CS# setup, a 6-byte command/address, a fixed 2x initial
// latency and two data bytes. All pad-facing outputs are registered so they change only
// on hbus_clk edges. The pad wrapper handles the 90deg CK/DQ shift and the tristates.

module hyperbus_ctrl #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int LATENCY_CK      = 6,
    parameter int RECOVERY_CLKS   = 2,
    parameter int RD_TIMEOUT      = 64
) (
    input  logic                       hbus_clk,
    input  logic                       hbus_rst_n,
    input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    input  logic [1:0]                 hbus_mask_i,
    input  logic                       hbus_rrq,
    input  logic                       hbus_wrq,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    output logic                       hbus_ready,
    output logic                       hbus_valid,
    output logic                       hbus_err,
    output logic                       busy,
    output logic                       hb_ck_o,
    output logic                       hb_cs_n_o,
    output logic                       hb_rst_n_o,
    input  logic                       hb_rwds_i,
    output logic                       hb_rwds_o,
    output logic                       hb_rwds_oe,
    input  logic [7:0]                 hb_dq_i,
    output logic [7:0]                 hb_dq_o,
    output logic                       hb_dq_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSSETUP,
        S_CA,
        S_LAT,
        S_WDATA,
        S_RDATA,
        S_END,
        S_RECOVER
    } state_t;

    // 2x latency: 2 * LATENCY_CK CK cycles, each CK cycle is two hbus_clk cycles
    localparam logic [15:0] LAT_LAST = 16'(4 * LATENCY_CK - 1);
    localparam logic [15:0] TO_LAST  = 16'(RD_TIMEOUT - 1);
    localparam logic [15:0] REC_LAST = 16'(RECOVERY_CLKS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [47:0] ca_q, ca_d;
    logic [15:0] wdat_q, wdat_d;
    logic [1:0]  mask_q, mask_d;
    logic        is_rd_q, is_rd_d;
    logic [7:0]  hi_q, hi_d;
    logic        got_hi_q, got_hi_d;
    logic        rwds_r_q, rwds_p_q;
    logic [7:0]  dq_r_q;
    logic [15:0] dat_o_q, dat_o_d;
    logic        cs_n_q, cs_n_d;
    logic        ck_q, ck_d;
    logic [7:0]  dq_o_q, dq_o_d;
    logic        dq_oe_q, dq_oe_d;
    logic        rwds_o_q, rwds_o_d;
    logic        rwds_oe_q, rwds_oe_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [31:0] w_ext;
    logic        rwds_edge;
    logic        unused_adr_lsb;

    // Half-word address, zero-extended or truncated to the 32 bits the CA format carries
    assign w_ext          = 32'(hbus_adr_i[HBUS_ADDR_WIDTH-1:1]);
    assign unused_adr_lsb = hbus_adr_i[0];
    assign rwds_edge      = rwds_r_q ^ rwds_p_q;

    // Next-state and next-output logic; every output is the registered version of its _d
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ca_d      = ca_q;
        wdat_d    = wdat_q;
        mask_d    = mask_q;
        is_rd_d   = is_rd_q;
        hi_d      = hi_q;
        got_hi_d  = got_hi_q;
        dat_o_d   = dat_o_q;
        cs_n_d    = cs_n_q;
        ck_d      = 1'b0;
        dq_o_d    = 8'h00;
        dq_oe_d   = 1'b0;
        rwds_o_d  = 1'b0;
        rwds_oe_d = 1'b0;
        ready_d   = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                if (hbus_wrq || hbus_rrq) begin
                    state_d = S_CSSETUP;
                    cs_n_d  = 1'b0;
                    is_rd_d = ~hbus_wrq;
                    ca_d    = {~hbus_wrq, 1'b0, 1'b1, w_ext[31:3], 13'd0, w_ext[2:0]};
                    wdat_d  = hbus_dat_i;
                    mask_d  = hbus_mask_i;
                end
            end
            S_CSSETUP: begin
                state_d = S_CA;
                cnt_d   = 16'd0;
                dq_o_d  = ca_q[47:40];
                dq_oe_d = 1'b1;
                ck_d    = 1'b1;
                ca_d    = {ca_q[39:0], 8'h00};
            end
            S_CA: begin
                ck_d = ~ck_q;
                if (cnt_q == 16'd5) begin
                    state_d = S_LAT;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    dq_o_d  = ca_q[47:40];
                    dq_oe_d = 1'b1;
                    ca_d    = {ca_q[39:0], 8'h00};
                end
            end
            S_LAT: begin
                ck_d = ~ck_q;
                if (cnt_q == LAT_LAST) begin
                    cnt_d = 16'd0;
                    if (is_rd_q) begin
                        state_d  = S_RDATA;
                        got_hi_d = 1'b0;
                    end else begin
                        state_d   = S_WDATA;
                        dq_o_d    = wdat_q[15:8];
                        dq_oe_d   = 1'b1;
                        rwds_o_d  = mask_q[1];
                        rwds_oe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WDATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d     = 16'd1;
                    ck_d      = ~ck_q;
                    dq_o_d    = wdat_q[7:0];
                    dq_oe_d   = 1'b1;
                    rwds_o_d  = mask_q[0];
                    rwds_oe_d = 1'b1;
                end else begin
                    state_d = S_END;
                    cs_n_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            S_RDATA: begin
                if (rwds_edge && got_hi_q) begin
                    state_d = S_END;
                    cs_n_d  = 1'b1;
                    dat_o_d = {hi_q, dq_r_q};
                    valid_d = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_END;
                    cs_n_d  = 1'b1;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    ck_d  = ~ck_q;
                    cnt_d = cnt_q + 16'd1;
                    if (rwds_edge) begin
                        hi_d     = dq_r_q;
                        got_hi_d = 1'b1;
                    end
                end
            end
            S_END: begin
                cs_n_d  = 1'b1;
                cnt_d   = 16'd0;
                state_d = (RECOVERY_CLKS > 0) ? S_RECOVER : S_IDLE;
            end
            S_RECOVER: begin
                cs_n_d = 1'b1;
                if (cnt_q == REC_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // All state and pad outputs; reset aborts any transaction immediately
    always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
        if (!hbus_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            ca_q      <= 48'd0;
            wdat_q    <= 16'd0;
            mask_q    <= 2'b00;
            is_rd_q   <= 1'b0;
            hi_q      <= 8'h00;
            got_hi_q  <= 1'b0;
            rwds_r_q  <= 1'b0;
            rwds_p_q  <= 1'b0;
            dq_r_q    <= 8'h00;
            dat_o_q   <= 16'd0;
            cs_n_q    <= 1'b1;
            ck_q      <= 1'b0;
            dq_o_q    <= 8'h00;
            dq_oe_q   <= 1'b0;
            rwds_o_q  <= 1'b0;
            rwds_oe_q <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ca_q      <= ca_d;
            wdat_q    <= wdat_d;
            mask_q    <= mask_d;
            is_rd_q   <= is_rd_d;
            hi_q      <= hi_d;
            got_hi_q  <= got_hi_d;
            rwds_r_q  <= hb_rwds_i;
            rwds_p_q  <= rwds_r_q;
            dq_r_q    <= hb_dq_i;
            dat_o_q   <= dat_o_d;
            cs_n_q    <= cs_n_d;
            ck_q      <= ck_d;
            dq_o_q    <= dq_o_d;
            dq_oe_q   <= dq_oe_d;
            rwds_o_q  <= rwds_o_d;
            rwds_oe_q <= rwds_oe_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign hbus_dat_o = dat_o_q;
    assign hbus_ready = ready_q;
    assign hbus_valid = valid_q;
    assign hbus_err   = err_q;
    assign busy       = busy_q;
    assign hb_ck_o    = ck_q;
    assign hb_cs_n_o  = cs_n_q;
    assign hb_rst_n_o = hbus_rst_n;
    assign hb_rwds_o  = rwds_o_q;
    assign hb_rwds_oe = rwds_oe_q;
    assign hb_dq_o    = dq_o_q;
    assign hb_dq_oe   = dq_oe_q;

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// tb_hyperbus_ctrl: directed scenarios for hyperbus_ctrl with hand-computed expectations.
// "Cycle n" counts hbus_clk cycles from the cycle in which the request was presented
// (cycle 0); outputs are sampled 1 time unit after each rising edge.

module tb_hyperbus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr = '0;
    logic [15:0] dat = '0;
    logic [1:0]  mask = '0;
    logic        rrq = 1'b0;
    logic        wrq = 1'b0;
    logic [15:0] dat_o;
    logic        ready, valid, err, busy;
    logic        ck, cs_n, hb_rst_n, rwds_o, rwds_oe, dq_oe;
    logic        rwds_in = 1'b0;
    logic [7:0]  dq_in = '0;
    logic [7:0]  dq_o;

    int n_checks = 0;
    int n_fail = 0;

    hyperbus_ctrl dut (
        .hbus_clk    (clk),
        .hbus_rst_n  (rst_n),
        .hbus_adr_i  (adr),
        .hbus_dat_i  (dat),
        .hbus_mask_i (mask),
        .hbus_rrq    (rrq),
        .hbus_wrq    (wrq),
        .hbus_dat_o  (dat_o),
        .hbus_ready  (ready),
        .hbus_valid  (valid),
        .hbus_err    (err),
        .busy        (busy),
        .hb_ck_o     (ck),
        .hb_cs_n_o   (cs_n),
        .hb_rst_n_o  (hb_rst_n),
        .hb_rwds_i   (rwds_in),
        .hb_rwds_o   (rwds_o),
        .hb_rwds_oe  (rwds_oe),
        .hb_dq_i     (dq_in),
        .hb_dq_o     (dq_o),
        .hb_dq_oe    (dq_oe)
    );

    // Free-running hbus_clk
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in cycle 1
    task automatic start_req(input logic w, input logic r, input logic [31:0] a,
                             input logic [15:0] d, input logic [1:0] m);
        adr  = a;
        dat  = d;
        mask = m;
        wrq  = w;
        rrq  = r;
        step();
        wrq  = 1'b0;
        rrq  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({cs_n, ck, dq_oe, rwds_oe, rwds_o, ready, valid, err, busy} !== 9'b100000000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b",
                     {cs_n, ck, dq_oe, rwds_oe, rwds_o, ready, valid, err, busy}, 9'b100000000);
        end
        n_checks++;
        if (dq_o !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_dq_o: got %h expected 00", dq_o);
        end
        n_checks++;
        if (dat_o !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_dat_o: got %h expected 0000", dat_o);
        end
        n_checks++;
        if (hb_rst_n !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_hb_rst_n: got %b expected 0", hb_rst_n);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (hb_rst_n !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL release_hb_rst_n: got %b expected 1", hb_rst_n);
        end
    endtask

    task automatic test_write();
        logic [7:0] exp_ca [6] = '{8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        start_req(1'b1, 1'b0, 32'h10, 16'hBEEF, 2'b00);
        for (int c = 1; c <= 37; c++) begin
            if (c > 1) step();
            if (c == 1) begin
                n_checks++;
                if ({cs_n, busy, ck, dq_oe} !== 4'b0100) begin
                    n_fail++;
                    $display("[TB] FAIL wr_cssetup: got %b expected 0100", {cs_n, busy, ck, dq_oe});
                end
            end
            if (c >= 2 && c <= 7) begin
                n_checks++;
                if ({dq_oe, dq_o} !== {1'b1, exp_ca[c-2]}) begin
                    n_fail++;
                    $display("[TB] FAIL wr_ca_byte%0d: got oe=%b dq=%h expected oe=1 dq=%h",
                             c - 2, dq_oe, dq_o, exp_ca[c-2]);
                end
            end
            if (c == 2 || c == 3) begin
                n_checks++;
                if (ck !== (c == 2)) begin
                    n_fail++;
                    $display("[TB] FAIL wr_ck_c%0d: got %b expected %b", c, ck, (c == 2));
                end
            end
            if (c == 8) begin
                n_checks++;
                if ({dq_oe, rwds_oe, cs_n} !== 3'b000) begin
                    n_fail++;
                    $display("[TB] FAIL wr_lat_oe: got %b expected 000", {dq_oe, rwds_oe, cs_n});
                end
            end
            if (c == 32 || c == 33) begin
                n_checks++;
                if ({dq_oe, rwds_oe, rwds_o, cs_n, dq_o} !== {4'b1100, (c == 32) ? 8'hBE : 8'hEF}) begin
                    n_fail++;
                    $display("[TB] FAIL wr_data_c%0d: got oe=%b roe=%b rwds=%b cs_n=%b dq=%h expected 1 1 0 0 %h",
                             c, dq_oe, rwds_oe, rwds_o, cs_n, dq_o, (c == 32) ? 8'hBE : 8'hEF);
                end
                n_checks++;
                if (ck !== (c == 32)) begin
                    n_fail++;
                    $display("[TB] FAIL wr_data_ck_c%0d: got %b expected %b", c, ck, (c == 32));
                end
            end
            if (c >= 33 && c <= 35) begin
                n_checks++;
                if (ready !== (c == 34)) begin
                    n_fail++;
                    $display("[TB] FAIL wr_ready_c%0d: got %b expected %b", c, ready, (c == 34));
                end
            end
            if (c == 34) begin
                n_checks++;
                if ({cs_n, ck, dq_oe, rwds_oe, valid} !== 5'b10000) begin
                    n_fail++;
                    $display("[TB] FAIL wr_end: got %b expected 10000", {cs_n, ck, dq_oe, rwds_oe, valid});
                end
            end
            if (c == 36 || c == 37) begin
                n_checks++;
                if (busy !== (c == 36)) begin
                    n_fail++;
                    $display("[TB] FAIL wr_busy_c%0d: got %b expected %b", c, busy, (c == 36));
                end
            end
        end
    endtask

    task automatic test_read();
        logic [7:0] exp_ca [6] = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
        int seen = 0;
        rwds_in = 1'b0;
        dq_in   = 8'h00;
        start_req(1'b0, 1'b1, 32'h6, 16'h0000, 2'b00);
        for (int c = 1; c <= 100 && seen == 0; c++) begin
            if (c > 1) step();
            if (c >= 2 && c <= 7) begin
                n_checks++;
                if (dq_o !== exp_ca[c-2]) begin
                    n_fail++;
                    $display("[TB] FAIL rd_ca_byte%0d: got %h expected %h", c - 2, dq_o, exp_ca[c-2]);
                end
            end
            if (c == 33) begin
                n_checks++;
                if ({dq_oe, rwds_oe, cs_n} !== 3'b000) begin
                    n_fail++;
                    $display("[TB] FAIL rd_data_oe: got %b expected 000", {dq_oe, rwds_oe, cs_n});
                end
                dq_in   = 8'h12;
                rwds_in = 1'b1;
            end else if (c == 34) begin
                dq_in   = 8'h34;
                rwds_in = 1'b0;
            end
            if (valid === 1'b1) seen = c;
        end
        n_checks++;
        if (seen == 0) begin
            n_fail++;
            $display("[TB] FAIL rd_valid_timeout: got no valid expected valid within 100 cycles");
        end else begin
            n_checks++;
            if ({dat_o, err, cs_n} !== {16'h1234, 1'b0, 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL rd_result: got dat=%h err=%b cs_n=%b expected dat=1234 err=0 cs_n=1",
                         dat_o, err, cs_n);
            end
            step();
            n_checks++;
            if ({valid, err, busy} !== 3'b001) begin
                n_fail++;
                $display("[TB] FAIL rd_valid_pulse: got %b expected 001", {valid, err, busy});
            end
            step();
            step();
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rd_idle: got %b expected 0", busy);
            end
        end
    endtask

    task automatic test_write_mask();
        start_req(1'b1, 1'b0, 32'h0, 16'hAA55, 2'b10);
        for (int c = 1; c <= 37; c++) begin
            if (c > 1) step();
            if (c == 32 || c == 33) begin
                n_checks++;
                if ({rwds_oe, rwds_o, dq_o} !== {1'b1, (c == 32), (c == 32) ? 8'hAA : 8'h55}) begin
                    n_fail++;
                    $display("[TB] FAIL mask_c%0d: got roe=%b rwds=%b dq=%h expected 1 %b %h",
                             c, rwds_oe, rwds_o, dq_o, (c == 32), (c == 32) ? 8'hAA : 8'h55);
                end
            end
            if (c == 34) begin
                n_checks++;
                if (ready !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL mask_ready: got %b expected 1", ready);
                end
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mask_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_read_timeout();
        int early = 0;
        rwds_in = 1'b0;
        dq_in   = 8'h77;
        start_req(1'b0, 1'b1, 32'h100, 16'h0000, 2'b00);
        for (int c = 1; c <= 96; c++) begin
            if (c > 1) step();
            if (c < 96 && (valid === 1'b1 || err === 1'b1)) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("[TB] FAIL to_early: got %0d early pulse cycles expected 0", early);
        end
        n_checks++;
        if ({valid, err, cs_n, dat_o} !== {3'b111, 16'h1234}) begin
            n_fail++;
            $display("[TB] FAIL to_result: got valid=%b err=%b cs_n=%b dat=%h expected 1 1 1 1234",
                     valid, err, cs_n, dat_o);
        end
        step();
        n_checks++;
        if ({valid, err} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL to_pulse: got %b expected 00", {valid, err});
        end
        step();
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL to_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int n_ready = 0;
        int n_valid = 0;
        int n_busy  = 0;
        start_req(1'b1, 1'b1, 32'h10, 16'h1234, 2'b00);
        for (int c = 1; c <= 37; c++) begin
            if (c > 1) step();
            if (c == 2) begin
                n_checks++;
                if (dq_o !== 8'h20) begin
                    n_fail++;
                    $display("[TB] FAIL both_ca0: got %h expected 20", dq_o);
                end
            end
            if (ready === 1'b1) n_ready++;
            if (valid === 1'b1) n_valid++;
            if (c == 10) rrq = 1'b1;
            if (c == 11) rrq = 1'b0;
        end
        n_checks++;
        if (n_ready != 1 || n_valid != 0) begin
            n_fail++;
            $display("[TB] FAIL both_pulses: got ready=%0d valid=%0d expected ready=1 valid=0", n_ready, n_valid);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            if (busy === 1'b1) n_busy++;
        end
        n_checks++;
        if (n_busy != 0) begin
            n_fail++;
            $display("[TB] FAIL busy_rrq_ignored: got %0d busy cycles expected 0", n_busy);
        end
    endtask

    task automatic test_reset_midway();
        start_req(1'b1, 1'b0, 32'h10, 16'hBEEF, 2'b00);
        for (int c = 2; c <= 15; c++) step();
        n_checks++;
        if ({busy, cs_n} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL mid_pre: got %b expected 10", {busy, cs_n});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cs_n, ck, dq_oe, rwds_oe, busy, hb_rst_n} !== 6'b100000) begin
            n_fail++;
            $display("[TB] FAIL mid_abort: got %b expected 100000", {cs_n, ck, dq_oe, rwds_oe, busy, hb_rst_n});
        end
        step();
        rst_n = 1'b1;
        step();
        start_req(1'b1, 1'b0, 32'h10, 16'hBEEF, 2'b00);
        for (int c = 1; c <= 37; c++) begin
            if (c > 1) step();
            if (c == 32 || c == 33) begin
                n_checks++;
                if (dq_o !== ((c == 32) ? 8'hBE : 8'hEF)) begin
                    n_fail++;
                    $display("[TB] FAIL mid_rerun_dq_c%0d: got %h expected %h", c, dq_o, (c == 32) ? 8'hBE : 8'hEF);
                end
            end
            if (c == 34) begin
                n_checks++;
                if (ready !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL mid_rerun_ready: got %b expected 1", ready);
                end
            end
        end
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] starting hyperbus_ctrl bench");
        test_reset();
        test_write();
        test_read();
        test_write_mask();
        test_read_timeout();
        test_back_to_back();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
